// File: rtl/vreg_write_sequencer.sv
// Write-port sequencer for the 16x4x32 vector register set: round-robin arbitration between
// ALU writeback (src0) and memory load (src1), one register-file write per enabled lane.
module vreg_write_sequencer #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int ROW_AW = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [ROW_AW-1:0]       req_row0,
  input  logic [ROW_AW-1:0]       req_row1,
  input  logic [LANES*DATA_W-1:0] req_data0,
  input  logic [LANES*DATA_W-1:0] req_data1,
  input  logic [LANES-1:0]        req_mask0,
  input  logic [LANES-1:0]        req_mask1,
  output logic                    writeEnable,
  output logic [ROW_AW-1:0]       writeAddressR,
  output logic [1:0]              writeAddressC,
  output logic [DATA_W-1:0]       writeData,
  output logic                    busy_valid,
  output logic [ROW_AW-1:0]       busy_row,
  output logic                    done,
  output logic                    done_src
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                  state, state_n;
  logic [ROW_AW-1:0]       row_q;
  logic [LANES*DATA_W-1:0] data_q;
  logic [LANES-1:0]        rem_q, rem_n;
  logic                    src_q;
  logic                    ptr;
  logic                    done_q;
  logic [1:0]              col_q;

  logic [1:0]              low_col;
  logic [1:0]              out_col;
  logic                    last_lane;
  logic                    accepting;
  logic                    grant_src;
  logic                    accept;
  logic [ROW_AW-1:0]       sel_row;
  logic [LANES*DATA_W-1:0] sel_data;
  logic [LANES-1:0]        sel_mask;
  logic [DATA_W-1:0]       lane_data [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_data[g] = data_q[g*DATA_W +: DATA_W];
  end

  always_comb begin
    low_col = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (rem_q[i]) low_col = 2'(i);
    end
  end

  assign last_lane = (state == WRITE) && (rem_q != '0) && ((rem_q & (rem_q - LANES'(1))) == '0);
  assign accepting = reset && ((state == IDLE) || last_lane);
  assign grant_src = (req_valid == 2'b11) ? ptr : req_valid[1];
  assign req_ready = accepting ? (grant_src ? 2'b10 : 2'b01) : 2'b00;
  assign accept    = |(req_valid & req_ready);

  assign sel_row  = grant_src ? req_row1  : req_row0;
  assign sel_data = grant_src ? req_data1 : req_data0;
  assign sel_mask = grant_src ? req_mask1 : req_mask0;

  always_comb begin
    state_n = state;
    rem_n   = rem_q;
    if (state == WRITE) begin
      rem_n   = rem_q & (rem_q - LANES'(1));
      state_n = last_lane ? IDLE : WRITE;
    end
    if (accept) begin
      rem_n = sel_mask;
      if (sel_mask != '0) state_n = WRITE;
    end
  end

  // Row/data only load on a non-zero mask so the write-port outputs stay frozen outside WRITE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      rem_q  <= '0;
      ptr    <= 1'b0;
      done_q <= 1'b0;
      row_q  <= '0;
      data_q <= '0;
      src_q  <= 1'b0;
      col_q  <= '0;
    end else begin
      state  <= state_n;
      rem_q  <= rem_n;
      done_q <= accept && (sel_mask == '0);
      if (state == WRITE) col_q <= low_col;
      if (accept) begin
        ptr   <= ~grant_src;
        src_q <= grant_src;
        if (sel_mask != '0) begin
          row_q  <= sel_row;
          data_q <= sel_data;
        end
      end
    end
  end

  assign out_col       = (state == WRITE) ? low_col : col_q;
  assign writeEnable   = (state == WRITE);
  assign writeAddressR = row_q;
  assign writeAddressC = out_col;
  assign writeData     = lane_data[out_col];
  assign busy_valid    = (state == WRITE);
  assign busy_row      = row_q;
  assign done          = done_q || last_lane;
  assign done_src      = src_q;

endmodule

// File: tb/tb_vreg_write_sequencer.sv
// Directed self-checking bench for vreg_write_sequencer; inputs change and outputs are sampled 1ns after each rising edge.
module tb_vreg_write_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [3:0]   req_row0, req_row1;
  logic [127:0] req_data0, req_data1;
  logic [3:0]   req_mask0, req_mask1;
  logic         writeEnable;
  logic [3:0]   writeAddressR;
  logic [1:0]   writeAddressC;
  logic [31:0]  writeData;
  logic         busy_valid;
  logic [3:0]   busy_row;
  logic         done;
  logic         done_src;

  int checkCount = 0;
  int errorCount = 0;

  vreg_write_sequencer #(.DATA_W(32), .LANES(4), .ROW_AW(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_row0(req_row0), .req_row1(req_row1),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_mask0(req_mask0), .req_mask1(req_mask1),
    .writeEnable(writeEnable), .writeAddressR(writeAddressR),
    .writeAddressC(writeAddressC), .writeData(writeData),
    .busy_valid(busy_valid), .busy_row(busy_row),
    .done(done), .done_src(done_src)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic src, input logic [3:0] row, input logic [127:0] data, input logic [3:0] mask);
    if (src) begin
      req_row1 = row; req_data1 = data; req_mask1 = mask; req_valid[1] = 1'b1;
    end else begin
      req_row0 = row; req_data0 = data; req_mask0 = mask; req_valid[0] = 1'b1;
    end
    #1;
  endtask

  task automatic checkWrite(input string tag, input logic [3:0] row, input logic [1:0] col,
                            input logic [31:0] data, input logic dn, input logic dsrc);
    checkOutput({tag, ".we"},   64'(writeEnable),   64'(1'b1));
    checkOutput({tag, ".row"},  64'(writeAddressR), 64'(row));
    checkOutput({tag, ".col"},  64'(writeAddressC), 64'(col));
    checkOutput({tag, ".data"}, 64'(writeData),     64'(data));
    checkOutput({tag, ".busy"}, 64'({busy_valid, busy_row}), 64'({1'b1, row}));
    checkOutput({tag, ".done"}, 64'(done), 64'(dn));
    if (dn) checkOutput({tag, ".dsrc"}, 64'(done_src), 64'(dsrc));
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 2'b00;
    req_row0 = '0; req_row1 = '0; req_data0 = '0; req_data1 = '0; req_mask0 = '0; req_mask1 = '0;
    step();
    // Both sources already requesting while reset is held.
    applyStimulus(1'b0, 4'd1, {96'h0, 32'hA0}, 4'b0001);
    applyStimulus(1'b1, 4'd2, {96'h0, 32'hB0}, 4'b0001);
    step();
    checkOutput("rst.ready", 64'(req_ready), 64'(2'b00));
    checkOutput("rst.flags", 64'({writeEnable, busy_valid, done}), 64'(3'b000));
    checkOutput("rst.addr", 64'({writeAddressR, writeAddressC}), 64'(0));
    checkOutput("rst.data", 64'(writeData), 64'(0));
    checkOutput("rst.busyrow", 64'({busy_row, done_src}), 64'(0));

    // Contention: alternating grants with no bubbles.
    reset = 1'b1;
    #1;
    checkOutput("rr.ready0", 64'(req_ready), 64'(2'b01));
    step();
    checkWrite("rr.w0", 4'd1, 2'd0, 32'hA0, 1'b1, 1'b0);
    checkOutput("rr.ready1", 64'(req_ready), 64'(2'b10));
    step();
    checkWrite("rr.w1", 4'd2, 2'd0, 32'hB0, 1'b1, 1'b1);
    checkOutput("rr.ready2", 64'(req_ready), 64'(2'b01));
    step();
    checkWrite("rr.w2", 4'd1, 2'd0, 32'hA0, 1'b1, 1'b0);
    req_valid = 2'b00;
    step();
    checkOutput("rr.idle", 64'({writeEnable, busy_valid, done}), 64'(3'b000));
    checkOutput("rr.hold", 64'({writeAddressR, writeAddressC, writeData}), 64'({4'd1, 2'd0, 32'hA0}));

    // Full mask from src0, with src1 stalled until the last lane.
    applyStimulus(1'b0, 4'd5, {32'h13, 32'h12, 32'h11, 32'h10}, 4'b1111);
    checkOutput("full.ready", 64'(req_ready), 64'(2'b01));
    step();
    req_valid[0] = 1'b0;
    applyStimulus(1'b1, 4'd9, {32'h2D, 32'h2C, 32'h2B, 32'h2A}, 4'b1010);
    for (int k = 0; k < 4; k++) begin
      checkWrite($sformatf("full.w%0d", k), 4'd5, 2'(k), 32'h10 + 32'(k), k == 3, 1'b0);
      checkOutput($sformatf("stall.ready%0d", k), 64'(req_ready), (k == 3) ? 64'(2'b10) : 64'(2'b00));
      if (k < 3) step();
    end
    step();
    req_valid[1] = 1'b0;
    // Sparse src1 write; a zero-mask src0 request arrives on its last lane.
    checkWrite("sparse.w0", 4'd9, 2'd1, 32'h2B, 1'b0, 1'b0);
    step();
    checkWrite("sparse.w1", 4'd9, 2'd3, 32'h2D, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'd4, {32'hEE, 32'hEE, 32'hEE, 32'hEE}, 4'b0000);
    checkOutput("zlast.ready", 64'(req_ready), 64'(2'b01));
    step();
    req_valid = 2'b00;
    checkOutput("zlast.we", 64'({writeEnable, busy_valid}), 64'(2'b00));
    checkOutput("zlast.done", 64'({done, done_src}), 64'(2'b10));
    checkOutput("zlast.hold", 64'({writeAddressR, writeAddressC, writeData}), 64'({4'd9, 2'd3, 32'h2D}));
    step();
    checkOutput("zlast.done2", 64'(done), 64'(0));

    // Zero mask accepted from IDLE.
    applyStimulus(1'b0, 4'd6, {32'h1, 32'h2, 32'h3, 32'h4}, 4'b0000);
    checkOutput("zidle.ready", 64'(req_ready), 64'(2'b01));
    step();
    req_valid = 2'b00;
    checkOutput("zidle.we", 64'(writeEnable), 64'(0));
    checkOutput("zidle.done", 64'({done, done_src}), 64'(2'b10));
    checkOutput("zidle.row", 64'(writeAddressR), 64'(4'd9));
    step();
    checkOutput("zidle.done2", 64'(done), 64'(0));

    // Reset after the second write of a full-mask request.
    applyStimulus(1'b0, 4'd3, {32'h33, 32'h32, 32'h31, 32'h30}, 4'b1111);
    step();
    req_valid = 2'b00;
    checkWrite("rmid.w0", 4'd3, 2'd0, 32'h30, 1'b0, 1'b0);
    step();
    checkWrite("rmid.w1", 4'd3, 2'd1, 32'h31, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    checkOutput("rmid.flags", 64'({writeEnable, busy_valid, done}), 64'(3'b000));
    checkOutput("rmid.row", 64'(writeAddressR), 64'(0));
    step();
    checkOutput("rmid.flags2", 64'({writeEnable, busy_valid, done}), 64'(3'b000));
    reset = 1'b1;
    applyStimulus(1'b1, 4'd7, {32'h73, 32'h72, 32'h71, 32'h70}, 4'b0100);
    checkOutput("rmid.ready", 64'(req_ready), 64'(2'b10));
    step();
    req_valid = 2'b00;
    checkWrite("rmid.after", 4'd7, 2'd2, 32'h72, 1'b1, 1'b1);
    step();
    checkOutput("rmid.end", 64'({writeEnable, busy_valid, done}), 64'(3'b000));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/vreg_write_sequencer.md
Name: vreg_write_sequencer

Overview:
- Write-port controller for the 16-row x 4-lane x 32-bit vector register set, which has one 32-bit write port addressed by row (writeAddressR) and column (writeAddressC).
- Two requesters present whole-vector writes: src0 is ALU writeback and src1 is memory load. Each request carries a row, 4 lanes of data and a lane mask.
- The block arbitrates round-robin between the requesters and serializes each accepted vector into one register-file write per enabled lane.
- It exports the row being written so the issue stage can stall dependent reads.

Parameters:
- DATA_W, 32: width of one lane.
- LANES, 4: lanes per row; fixed at 4 because writeAddressC is 2 bits.
- ROW_AW, 4: row address width (16 rows).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-low.
- req_valid  in  2  per-source request valid; bit 0 = ALU, bit 1 = load.
- req_ready  out  2  per-source accept.
- req_row0, req_row1  in  ROW_AW  target row.
- req_data0, req_data1  in  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- req_mask0, req_mask1  in  LANES  lane write enables.
- writeEnable  out  1  register-file write strobe.
- writeAddressR  out  ROW_AW  register-file row.
- writeAddressC  out  2  register-file column.
- writeData  out  DATA_W  register-file data.
- busy_valid  out  1  a row write is in progress.
- busy_row  out  ROW_AW  row being written.
- done  out  1  one-cycle pulse when a request completes.
- done_src  out  1  source of the completed request; valid only while done=1.

Behaviour:
- Reset (reset=0 at a rising edge):
  - State returns to IDLE; the remaining-mask register clears; the round-robin pointer is set to favour src0.
  - The done register clears.
  - Consequently writeEnable, busy_valid, done and req_ready are all 0 while reset is held.
  - writeAddressR, writeAddressC, writeData, busy_row and done_src are 0 while reset is held.
- States: IDLE and WRITE. Registers: row_q, data_q, rem_q (remaining mask), src_q, ptr (round-robin pointer).
- Grant (combinational):
  - Issued when "accepting", i.e. state==IDLE, or state==WRITE with exactly one bit set in rem_q (the last write cycle).
  - If both requests are valid, the source that ptr favours wins. Otherwise the sole valid source wins.
  - req_ready[s] = accepting && (granted source == s). At most one ready bit is high; ready never depends on the other source's ready.
- Accept: a request is accepted when req_valid[s] && req_ready[s] at a rising edge.
  - row, data, mask and source are captured.
  - ptr moves to favour the other source.
- Mask non-zero on accept: next state is WRITE with rem_q = mask.
- Mask zero on accept: no write cycles; state goes to or stays in IDLE; done=1 with done_src=s in the following cycle.
- WRITE state outputs (combinational from registers):
  - writeEnable=1.
  - writeAddressR=row_q.
  - writeAddressC = index of the lowest set bit of rem_q.
  - writeData = lane of data_q at that index.
  - busy_valid=1, busy_row=row_q.
- WRITE state update: each cycle the lowest set bit of rem_q clears.
  - When rem_q has one bit set, that cycle is the last write. done=1 in that same cycle with done_src=src_q.
  - The next state is WRITE if a new request is accepted in that cycle, otherwise IDLE.
- Latency:
  - A request with k enabled lanes produces exactly k consecutive writeEnable cycles, starting the cycle after accept.
  - Lanes are written in ascending column order; masked-off lanes take no cycle.
  - Back-to-back requests produce no bubble between them.
- Outside WRITE: writeEnable=0 and busy_valid=0. writeAddressR, writeAddressC and writeData are don't-care but must hold their last values (no toggling).
- Requesters must hold row, data and mask stable while valid is high and ready is low. Dropping valid before accept is permitted; no accept occurs.
- Reset asserted mid-WRITE: the remaining lanes are abandoned, no done is issued, and writeEnable=0 from the next cycle.
- done for a zero-mask accept and done for a last-lane write never coincide, because a zero-mask accept during a last-lane cycle pulses done in the following cycle.

Test Plan:
1. Single write, full mask: src0 requests row=5, mask=4'b1111, lanes=0x10,0x11,0x12,0x13 → 4 cycles with writeEnable=1, R=5, C=0,1,2,3, data 0x10..0x13. done on the 4th write cycle with done_src=0. busy_row=5 throughout.
2. Sparse mask: src1 requests row=9, mask=4'b1010 → 2 writes (C=1 then C=3) with that src1 request's lane-1 and lane-3 data; no cycle for lanes 0 and 2; done_src=1.
3. Contention: both sources valid continuously from reset, each with mask 4'b0001 → grants alternate src0, src1, src0, …; writeEnable stays high every cycle after the first accept (no bubbles).
4. Zero mask: src0 requests mask=0 in IDLE → req_ready=1, no writeEnable, done=1 the next cycle with done_src=0. Must also hold when the zero-mask request arrives during the last-lane cycle of a prior request (two separate done pulses).
5. Reset mid-operation: drive reset=0 after the 2nd write of a full-mask request → writeEnable=0, busy_valid=0, done=0 from the next cycle. After release, a new src1 request is accepted and writes normally.
6. Stall hold: src1 valid while a src0 4-lane write is in progress → req_ready[1]=0 until the src0 last-lane cycle, then accepted with its data unchanged.
